ptr_decode_init: RTL and testbench

- Support block for the 8-entry FIFO.
- Turns the FIFO write pointer and read pointer into one-hot register-select vectors (wrctrl, rdctrl) using two identical binary-to-one-hot decoders.
- Also holds an init sequencer. The sequencer turns the asynchronous system reset into a stretched, clock-aligned reset (init_rst) and a ready flag (init_done) for the FIFO and its port state machines.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/ptr_decode_init_if.sv | 23 ++
 rtl/ptr_decode_init_onehot_decoder.sv | 13 +
 rtl/ptr_decode_init.sv | 60 ++++++
 tb/tb_ptr_decode_init.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing for the 8-entry FIFO and its support logic.
package fifo_pkg;
    localparam int PTR_W       = 3;
    localparam int DEPTH       = 1 << PTR_W;
    localparam int INIT_CYCLES = 4;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [DEPTH-1:0] sel_t;

    typedef enum logic {
        INIT_HOLD = 1'b0,
        INIT_DONE = 1'b1
    } init_state_t;
endpackage

// File: rtl/ptr_decode_init_if.sv
// Pointer-in / select-out bundle between the FIFO control and ptr_decode_init.
interface ptr_decode_init_if #(
    parameter int WIDTH = 3
);
    localparam int DEPTH = 1 << WIDTH;

    logic [WIDTH-1:0] wrptr;
    logic [WIDTH-1:0] rdptr;
    logic [DEPTH-1:0] wrctrl;
    logic [DEPTH-1:0] rdctrl;
    logic             init_rst;
    logic             init_done;

    modport master (
        output wrptr, rdptr,
        input  wrctrl, rdctrl, init_rst, init_done
    );

    modport slave (
        input  wrptr, rdptr,
        output wrctrl, rdctrl, init_rst, init_done
    );
endinterface

// File: rtl/ptr_decode_init_onehot_decoder.sv
// Combinational binary-to-one-hot decoder; every defined input yields exactly one set bit.
module onehot_decoder #(
    parameter int WIDTH = 3
) (
    output logic [(1<<WIDTH)-1:0] out,
    input  logic [WIDTH-1:0]      in
);
    generate
        for (genvar gi = 0; gi < (1 << WIDTH); gi++) begin : g_bit
            assign out[gi] = (in == WIDTH'(gi));
        end
    endgenerate
endmodule

// File: rtl/ptr_decode_init.sv
// FIFO register-select decoders plus a reset stretcher that releases init_rst
// a fixed number of clock edges after the asynchronous reset falls.
module ptr_decode_init
    import fifo_pkg::*;
#(
    parameter int WIDTH        = PTR_W,
    parameter int RESET_CYCLES = INIT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    ptr_decode_init_if.slave   bus
);
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

    onehot_decoder #(.WIDTH(WIDTH)) u_wr_dec (
        .out (bus.wrctrl),
        .in  (bus.wrptr)
    );

    onehot_decoder #(.WIDTH(WIDTH)) u_rd_dec (
        .out (bus.rdctrl),
        .in  (bus.rdptr)
    );

    init_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             init_rst_reg;
    logic             init_done_reg;

    // Assertion is asynchronous; release happens on the RESET_CYCLES-th edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= INIT_HOLD;
            cnt_reg       <= '0;
            init_rst_reg  <= 1'b1;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT_HOLD: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg     <= INIT_DONE;
                        init_rst_reg  <= 1'b0;
                        init_done_reg <= 1'b1;
                    end
                end
                INIT_DONE: begin
                    state_reg <= INIT_DONE;
                end
                default: begin
                    state_reg <= INIT_HOLD;
                end
            endcase
        end
    end

    assign bus.init_rst  = init_rst_reg;
    assign bus.init_done = init_done_reg;
endmodule

// File: tb/tb_ptr_decode_init.sv
// Scoreboard bench for ptr_decode_init: default build plus a WIDTH=2, RESET_CYCLES=1 build.
module tb_ptr_decode_init;
    logic clock;
    logic reset;

    ptr_decode_init_if #(.WIDTH(3)) bus ();
    ptr_decode_init_if #(.WIDTH(2)) bus2 ();

    ptr_decode_init #(.WIDTH(3), .RESET_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ptr_decode_init #(.WIDTH(2), .RESET_CYCLES(1)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL sb_empty: got %h expected queued entry", act);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, act, e.exp);
        end
    endtask

    // Release reset already done by caller; walk the stretch edge by edge.
    task automatic run_stretch(input string name);
        sb_push({name, "_pre_rst"}, 32'd1);
        sb_push({name, "_pre_done"}, 32'd0);
        sb_push({name, "_pre_rst2"}, 32'd1);
        sb_pop_check({31'd0, bus.init_rst});
        sb_pop_check({31'd0, bus.init_done});
        sb_pop_check({31'd0, bus2.init_rst});
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            sb_push($sformatf("%s_e%0d_rst", name, k), (k < 4) ? 32'd1 : 32'd0);
            sb_push($sformatf("%s_e%0d_done", name, k), (k < 4) ? 32'd0 : 32'd1);
            sb_push($sformatf("%s_e%0d_rst2", name, k), 32'd0);
            sb_pop_check({31'd0, bus.init_rst});
            sb_pop_check({31'd0, bus.init_done});
            sb_pop_check({31'd0, bus2.init_rst});
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.wrptr  = '0;
        bus.rdptr  = '0;
        bus2.wrptr = '0;
        bus2.rdptr = '0;
        #2;
        sb_push("rst_init_rst", 32'd1);
        sb_push("rst_init_done", 32'd0);
        sb_pop_check({31'd0, bus.init_rst});
        sb_pop_check({31'd0, bus.init_done});

        // Decode sweep and wrap, all while reset is held high.
        for (int i = 0; i < 8; i++) begin
            bus.wrptr = 3'(i);
            bus.rdptr = 3'(7 - i);
            #1;
            sb_push($sformatf("dec_wr%0d", i), 32'(8'(1) << i));
            sb_push($sformatf("dec_rd%0d", i), 32'(8'(1) << (7 - i)));
            sb_push($sformatf("onehot%0d", i), 32'd3);
            sb_pop_check({24'd0, bus.wrctrl});
            sb_pop_check({24'd0, bus.rdctrl});
            sb_pop_check({30'd0, $onehot(bus.wrctrl), $onehot(bus.rdctrl)});
        end
        begin
            logic [2:0] wrap_seq [3];
            logic [7:0] wrap_exp [3];
            wrap_seq = '{3'd6, 3'd7, 3'd0};
            wrap_exp = '{8'h40, 8'h80, 8'h01};
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                bus.wrptr = wrap_seq[i];
                @(posedge clock);
                #1;
                sb_push($sformatf("wrap%0d", i), {24'd0, wrap_exp[i]});
                sb_pop_check({24'd0, bus.wrctrl});
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus2.wrptr = 2'(i);
            bus2.rdptr = 2'(3 - i);
            #1;
            sb_push($sformatf("dec2_wr%0d", i), 32'(4'(1) << i));
            sb_push($sformatf("dec2_rd%0d", i), 32'(4'(1) << (3 - i)));
            sb_pop_check({28'd0, bus2.wrctrl});
            sb_pop_check({28'd0, bus2.rdctrl});
        end

        // Reset stretch: hold two cycles, release between edges.
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_stretch("stretch");

        // Mid-count reset: short pulse away from any edge.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        sb_push("mid_async_rst", 32'd1);
        sb_push("mid_async_done", 32'd0);
        sb_pop_check({31'd0, bus.init_rst});
        sb_pop_check({31'd0, bus.init_done});
        reset = 1'b0;
        run_stretch("mid");

        // Late reset after completion.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        sb_push("late_async_rst", 32'd1);
        sb_push("late_async_done", 32'd0);
        sb_push("late_async_rst2", 32'd1);
        sb_pop_check({31'd0, bus.init_rst});
        sb_pop_check({31'd0, bus.init_done});
        sb_pop_check({31'd0, bus2.init_rst});
        @(negedge clock);
        reset = 1'b0;
        run_stretch("late");

        if (sb_q.size() != 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
